pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Consumes hazard requests raised in ID and drives pipeline write enables, bubbles and flushes.
//   Sequences multi-cycle load-use stalls and the branch freeze/resolve window.
//   Sits between hazard detection (ID) and the PC, IF/ID and ID/EX registers.
//   Also keeps saturating stall and taken-branch counters for performance checks.
// PARAMETERS
//   LU_STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1)
//   BR_WAIT_MAX      2   max cycles in BR_WAIT before timeout (>=1)
//   CNT_W            16  width of performance counters
// PORTS
//   i_clk              in   1      clock; all state on rising edge
//   i_rst              in   1      asynchronous, active-high reset
//   i_load_use_req     in   1      load-use hazard detected for instr in ID
//   i_branch_req       in   1      beq decoded in ID
//   i_branch_resolved  in   1      1-cycle pulse: outstanding branch resolved in EX
//   i_branch_taken     in   1      branch outcome; valid only with i_branch_resolved
//   i_ext_stall        in   1      global freeze (memory not ready)
//   o_pc_we            out  1      PC write enable
//   o_if_id_we         out  1      IF/ID write enable
//   o_if_id_flush      out  1      load NOP into IF/ID this cycle
//   o_id_ex_bubble     out  1      load NOP into ID/EX this cycle
//   o_pc_sel_branch    out  1      PC takes branch target this cycle
//   o_br_timeout       out  1      1-cycle pulse: BR_WAIT expired without resolve
//   o_state            out  2      RUN=0, LU_STALL=1, BR_WAIT=2
//   o_stall_cnt        out  CNT_W  hazard stall cycles (o_pc_we=0, not ext stall), saturating
//   o_taken_cnt        out  CNT_W  taken branches, saturating
// BEHAVIOUR
//   Reset: state RUN, internal counter 0, o_stall_cnt=o_taken_cnt=0; all 1-bit outputs 0 while i_rst=1.
//   Outputs are Mealy (combinational from state + inputs).
//   Priority: i_ext_stall > i_load_use_req > i_branch_req.
//   i_ext_stall=1 (any state): all enables/bubble/flush/sel/timeout 0; state, counters frozen.
//   RUN, no request: pc_we=1, if_id_we=1, others 0.
//   RUN, load_use: pc_we=0, if_id_we=0, id_ex_bubble=1, stall_cnt++.
//     LU_STALL_CYCLES=1 -> stay RUN; else -> LU_STALL with cnt=1.
//   LU_STALL: same outputs as RUN load_use (inputs ignored); cnt++.
//     When cnt==LU_STALL_CYCLES-1 this cycle is last -> RUN, cnt=0.
//   RUN, branch_req (no load_use): pc_we=0, if_id_we=1, if_id_flush=1 (branch advances to EX,
//     no younger instr follows); stall_cnt++; -> BR_WAIT, cnt=0.
//   BR_WAIT, no resolve: pc_we=0, if_id_we=0, stall_cnt++, cnt++.
//     cnt==BR_WAIT_MAX-1 -> o_br_timeout=1, treat not taken (pc_we=1), -> RUN.
//   BR_WAIT, resolve: pc_we=1, pc_sel_branch=i_branch_taken, if_id_flush=i_branch_taken,
//     if_id_we=1; taken_cnt++ if taken; -> RUN. Resolve wins over timeout on same cycle.
//   i_branch_resolved outside BR_WAIT: ignored. i_load_use_req/i_branch_req in LU_STALL/BR_WAIT: ignored.
//   Counters saturate at all-ones; no wrap.
//   Reset mid-stall/mid-wait: immediate return to RUN, pending branch discarded.
// TESTING
//   Idle 10 cycles, no requests -> pc_we=if_id_we=1 every cycle, counters 0.
//   LU_STALL_CYCLES=2, load_use pulse 1 cycle -> 2 cycles pc_we=0, bubble=1; stall_cnt=2; state RUN.
//   branch_req, resolve+taken 2 cycles later -> flush, pc_we=0 x2, then pc_sel_branch=1, flush=1; taken_cnt=1.
//   branch_req, never resolve, BR_WAIT_MAX=2 -> o_br_timeout pulse on 2nd BR_WAIT cycle, pc_we=1, sel=0.
//   load_use+branch_req same cycle, ext_stall mid BR_WAIT -> load-use served first; freeze holds cnt/state.
//   Assert i_rst inside BR_WAIT -> outputs 0 immediately, state RUN, counters 0 after release.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns ID hazard requests into PC/IF-ID/ID-EX controls,
// sequences load-use bubbles and the branch resolve window, and keeps saturating perf counters.
module pipeline_stall_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int BR_WAIT_MAX     = 2,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_use_req,
  input  logic             i_branch_req,
  input  logic             i_branch_resolved,
  input  logic             i_branch_taken,
  input  logic             i_ext_stall,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_pc_sel_branch,
  output logic             o_br_timeout,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_BR_WAIT  = 2'd2;

  // Sequence counter only ever holds values up to max(LU_STALL_CYCLES, BR_WAIT_MAX)-1.
  localparam int CNT_MAX = (LU_STALL_CYCLES > BR_WAIT_MAX) ? LU_STALL_CYCLES : BR_WAIT_MAX;
  localparam int SEQ_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [SEQ_W-1:0] SEQ_ZERO = SEQ_W'(0);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] LU_LAST  = SEQ_W'(LU_STALL_CYCLES - 1);
  localparam logic [SEQ_W-1:0] BR_LAST  = SEQ_W'(BR_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [SEQ_W-1:0] seq_cnt_r;
  logic [SEQ_W-1:0] next_seq_cnt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;

  logic pc_we_s;
  logic if_id_we_s;
  logic if_id_flush_s;
  logic id_ex_bubble_s;
  logic pc_sel_branch_s;
  logic br_timeout_s;
  logic stall_inc_s;
  logic taken_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    if (en && (val != CNT_ONES)) begin
      sat_inc = val + CNT_ONE;
    end else begin
      sat_inc = val;
    end
  endfunction

  // Next-state and Mealy control decode; an external freeze suppresses everything.
  always_comb begin
    pc_we_s         = 1'b0;
    if_id_we_s      = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_bubble_s  = 1'b0;
    pc_sel_branch_s = 1'b0;
    br_timeout_s    = 1'b0;
    stall_inc_s     = 1'b0;
    taken_inc_s     = 1'b0;
    next_state_s    = state_r;
    next_seq_cnt_s  = seq_cnt_r;
    if (i_ext_stall) begin
      next_state_s   = state_r;
      next_seq_cnt_s = seq_cnt_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (i_load_use_req) begin
            id_ex_bubble_s = 1'b1;
            stall_inc_s    = 1'b1;
            if (LU_STALL_CYCLES == 1) begin
              next_state_s   = ST_RUN;
              next_seq_cnt_s = SEQ_ZERO;
            end else begin
              next_state_s   = ST_LU_STALL;
              next_seq_cnt_s = SEQ_ONE;
            end
          end else if (i_branch_req) begin
            // Branch moves on to EX; IF/ID gets a NOP so nothing younger follows it.
            if_id_we_s     = 1'b1;
            if_id_flush_s  = 1'b1;
            stall_inc_s    = 1'b1;
            next_state_s   = ST_BR_WAIT;
            next_seq_cnt_s = SEQ_ZERO;
          end else begin
            pc_we_s    = 1'b1;
            if_id_we_s = 1'b1;
          end
        end
        ST_LU_STALL: begin
          id_ex_bubble_s = 1'b1;
          stall_inc_s    = 1'b1;
          if (seq_cnt_r == LU_LAST) begin
            next_state_s   = ST_RUN;
            next_seq_cnt_s = SEQ_ZERO;
          end else begin
            next_seq_cnt_s = seq_cnt_r + SEQ_ONE;
          end
        end
        ST_BR_WAIT: begin
          if (i_branch_resolved) begin
            pc_we_s         = 1'b1;
            if_id_we_s      = 1'b1;
            pc_sel_branch_s = i_branch_taken;
            if_id_flush_s   = i_branch_taken;
            taken_inc_s     = i_branch_taken;
            next_state_s    = ST_RUN;
            next_seq_cnt_s  = SEQ_ZERO;
          end else if (seq_cnt_r == BR_LAST) begin
            // Timed out: fall through as not-taken.
            br_timeout_s   = 1'b1;
            pc_we_s        = 1'b1;
            if_id_we_s     = 1'b1;
            next_state_s   = ST_RUN;
            next_seq_cnt_s = SEQ_ZERO;
          end else begin
            stall_inc_s    = 1'b1;
            next_seq_cnt_s = seq_cnt_r + SEQ_ONE;
          end
        end
        default: begin
          next_state_s   = ST_RUN;
          next_seq_cnt_s = SEQ_ZERO;
        end
      endcase
    end
  end

  // State and sequence counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_RUN;
      seq_cnt_r <= SEQ_ZERO;
    end else begin
      state_r   <= next_state_s;
      seq_cnt_r <= next_seq_cnt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
      taken_cnt_r <= sat_inc(taken_cnt_r, taken_inc_s);
    end
  end

  // Controls are forced low for the whole time reset is held, not just after the edge.
  assign o_pc_we         = pc_we_s         & ~i_rst;
  assign o_if_id_we      = if_id_we_s      & ~i_rst;
  assign o_if_id_flush   = if_id_flush_s   & ~i_rst;
  assign o_id_ex_bubble  = id_ex_bubble_s  & ~i_rst;
  assign o_pc_sel_branch = pc_sel_branch_s & ~i_rst;
  assign o_br_timeout    = br_timeout_s    & ~i_rst;
  assign o_state         = state_r;
  assign o_stall_cnt     = stall_cnt_r;
  assign o_taken_cnt     = taken_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver queues the expected per-cycle
// response for each input vector, a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_use_req;
  logic       branch_req;
  logic       branch_resolved;
  logic       branch_taken;
  logic       ext_stall;
  logic       pc_we;
  logic       if_id_we;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       pc_sel_branch;
  logic       br_timeout;
  logic [1:0] state;
  logic [3:0] stall_cnt;
  logic [3:0] taken_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] exp_q[$];

  pipeline_stall_ctrl #(
    .LU_STALL_CYCLES(2),
    .BR_WAIT_MAX    (2),
    .CNT_W          (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_load_use_req   (load_use_req),
    .i_branch_req     (branch_req),
    .i_branch_resolved(branch_resolved),
    .i_branch_taken   (branch_taken),
    .i_ext_stall      (ext_stall),
    .o_pc_we          (pc_we),
    .o_if_id_we       (if_id_we),
    .o_if_id_flush    (if_id_flush),
    .o_id_ex_bubble   (id_ex_bubble),
    .o_pc_sel_branch  (pc_sel_branch),
    .o_br_timeout     (br_timeout),
    .o_state          (state),
    .o_stall_cnt      (stall_cnt),
    .o_taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  // iv = {rst, ext, ld, br, res, tk}; ov = {pc_we, if_id_we, flush, bubble, sel, timeout}
  task automatic step(input logic [5:0] iv, input logic [5:0] ov,
                      input logic [1:0] st, input logic [3:0] sc, input logic [3:0] tc);
    {rst, ext_stall, load_use_req, branch_req, branch_resolved, branch_taken} = iv;
    exp_q.push_back({ov, st, sc, tc});
    @(posedge clk);
    #1;
  endtask

  // Monitor: one observation per cycle, mid-cycle.
  initial begin
    logic [15:0] got;
    logic [15:0] exp_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, pc_sel_branch, br_timeout,
               state, stall_cnt, taken_cnt};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL cyc%0d ctrl got=%b_%b_%0d_%0d expected=%b_%b_%0d_%0d", cyc,
                   got[15:10], got[9:8], got[7:4], got[3:0],
                   exp_v[15:10], exp_v[9:8], exp_v[7:4], exp_v[3:0]);
        end
        cyc++;
      end
    end
  end

  initial begin
    int guard;
    {rst, ext_stall, load_use_req, branch_req, branch_resolved, branch_taken} = 6'b100000;
    @(posedge clk);
    #1;
    // reset state
    step(6'b100000, 6'b000000, 2'd0, 4'd0, 4'd0);
    // idle 10 cycles
    for (int i = 0; i < 10; i++) step(6'b000000, 6'b110000, 2'd0, 4'd0, 4'd0);
    // load-use pulse -> two bubble cycles
    step(6'b001000, 6'b000100, 2'd0, 4'd0, 4'd0);
    step(6'b000000, 6'b000100, 2'd1, 4'd1, 4'd0);
    step(6'b000000, 6'b110000, 2'd0, 4'd2, 4'd0);
    // branch, resolved taken two cycles later
    step(6'b000100, 6'b011000, 2'd0, 4'd2, 4'd0);
    step(6'b000000, 6'b000000, 2'd2, 4'd3, 4'd0);
    step(6'b000011, 6'b111010, 2'd2, 4'd4, 4'd0);
    step(6'b000000, 6'b110000, 2'd0, 4'd4, 4'd1);
    // branch, never resolved -> timeout on 2nd wait cycle
    step(6'b000100, 6'b011000, 2'd0, 4'd4, 4'd1);
    step(6'b000000, 6'b000000, 2'd2, 4'd5, 4'd1);
    step(6'b000000, 6'b110001, 2'd2, 4'd6, 4'd1);
    step(6'b000000, 6'b110000, 2'd0, 4'd6, 4'd1);
    // branch resolved not taken; then stray resolve in RUN is ignored
    step(6'b000100, 6'b011000, 2'd0, 4'd6, 4'd1);
    step(6'b000010, 6'b110000, 2'd2, 4'd7, 4'd1);
    step(6'b000011, 6'b110000, 2'd0, 4'd7, 4'd1);
    // load-use + branch together: load-use first, then branch, freeze mid wait
    step(6'b001100, 6'b000100, 2'd0, 4'd7, 4'd1);
    step(6'b000100, 6'b000100, 2'd1, 4'd8, 4'd1);
    step(6'b000100, 6'b011000, 2'd0, 4'd9, 4'd1);
    step(6'b010000, 6'b000000, 2'd2, 4'd10, 4'd1);
    step(6'b010011, 6'b000000, 2'd2, 4'd10, 4'd1);
    step(6'b000000, 6'b000000, 2'd2, 4'd10, 4'd1);
    step(6'b000000, 6'b110001, 2'd2, 4'd11, 4'd1);
    // freeze beats load-use in RUN
    step(6'b011000, 6'b000000, 2'd0, 4'd11, 4'd1);
    step(6'b000000, 6'b110000, 2'd0, 4'd11, 4'd1);
    // stall counter saturates at 15
    step(6'b001000, 6'b000100, 2'd0, 4'd11, 4'd1);
    step(6'b000000, 6'b000100, 2'd1, 4'd12, 4'd1);
    step(6'b001000, 6'b000100, 2'd0, 4'd13, 4'd1);
    step(6'b000000, 6'b000100, 2'd1, 4'd14, 4'd1);
    step(6'b001000, 6'b000100, 2'd0, 4'd15, 4'd1);
    step(6'b000000, 6'b000100, 2'd1, 4'd15, 4'd1);
    step(6'b000000, 6'b110000, 2'd0, 4'd15, 4'd1);
    // reset inside BR_WAIT; pending branch is discarded
    step(6'b000100, 6'b011000, 2'd0, 4'd15, 4'd1);
    step(6'b100000, 6'b000000, 2'd0, 4'd0, 4'd0);
    step(6'b100000, 6'b000000, 2'd0, 4'd0, 4'd0);
    step(6'b000000, 6'b110000, 2'd0, 4'd0, 4'd0);
    step(6'b000011, 6'b110000, 2'd0, 4'd0, 4'd0);
    step(6'b000000, 6'b110000, 2'd0, 4'd0, 4'd0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
